// File: rtl/exc_if.sv
// Retirement-event and PC-redirect bundle between the core/PC unit (master) and exc_sequencer (slave).
// exc_count is present only when EXC_COUNT_EN is defined.
interface exc_if;
  logic        instr_valid;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        exc_illegal;
  logic        exc_ovf;
  logic        exc_sys;
  logic        int_req;
  logic        eret;
  logic        redirect_ack;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [1:0]  cause;
  logic [31:0] epc;
  logic        ie;
  logic        in_handler;
  logic        halted;
`ifdef EXC_COUNT_EN
  logic [15:0] exc_count;
`endif

  modport master (
    output instr_valid, pc_cur, pc_next, exc_illegal, exc_ovf, exc_sys,
    output int_req, eret, redirect_ack,
`ifdef EXC_COUNT_EN
    input  exc_count,
`endif
    input  flush, redirect_valid, redirect_pc, cause, epc, ie, in_handler, halted
  );

  modport slave (
    input  instr_valid, pc_cur, pc_next, exc_illegal, exc_ovf, exc_sys,
    input  int_req, eret, redirect_ack,
`ifdef EXC_COUNT_EN
    output exc_count,
`endif
    output flush, redirect_valid, redirect_pc, cause, epc, ie, in_handler, halted
  );
endinterface

// File: rtl/exc_sequencer.sv
// Exception/interrupt entry and ERET return sequencer for the multicycle MIPS core.
// Optional feature macro EXC_COUNT_EN adds a saturating count of taken events (exc_count).
module exc_sequencer #(
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter logic        RST_IE   = 1'b1
) (
  input logic clk,
  input logic rst,
  exc_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    REDIR,
    HANDLER,
    RET,
    HALT
  } state_t;

  state_t      state_reg;
  logic        flush_reg;
  logic        redirect_valid_reg;
  logic [31:0] redirect_pc_reg;
  logic [1:0]  cause_reg;
  logic [31:0] epc_reg;
  logic        ie_reg;
  logic        in_handler_reg;
  logic        halted_reg;

  logic        sync_exc;
  logic        event_hit;
  logic [1:0]  event_cause;
  logic [31:0] event_epc;

  assign sync_exc = bus.exc_illegal | bus.exc_ovf | bus.exc_sys;

  // Fixed-priority pick; an interrupt lets the retiring instruction complete, so it returns to pc_next.
  always_comb begin
    event_hit   = 1'b0;
    event_cause = 2'b00;
    event_epc   = bus.pc_cur;
    if (bus.instr_valid) begin
      if (bus.exc_illegal) begin
        event_hit   = 1'b1;
        event_cause = 2'b01;
      end else if (bus.exc_ovf) begin
        event_hit   = 1'b1;
        event_cause = 2'b10;
      end else if (bus.exc_sys) begin
        event_hit   = 1'b1;
        event_cause = 2'b11;
      end else if (bus.int_req && ie_reg) begin
        event_hit   = 1'b1;
        event_cause = 2'b00;
        event_epc   = bus.pc_next;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg          <= IDLE;
      flush_reg          <= 1'b0;
      redirect_valid_reg <= 1'b0;
      redirect_pc_reg    <= 32'h0;
      cause_reg          <= 2'b00;
      epc_reg            <= 32'h0;
      ie_reg             <= RST_IE;
      in_handler_reg     <= 1'b0;
      halted_reg         <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (event_hit) begin
            cause_reg <= event_cause;
            epc_reg   <= event_epc;
            ie_reg    <= 1'b0;
            flush_reg <= 1'b1;
            state_reg <= SAVE;
          end
        end
        SAVE: begin
          flush_reg          <= 1'b0;
          redirect_pc_reg    <= VEC_BASE + {27'b0, cause_reg, 3'b000};
          redirect_valid_reg <= 1'b1;
          state_reg          <= REDIR;
        end
        REDIR: begin
          if (bus.redirect_ack) begin
            redirect_valid_reg <= 1'b0;
            in_handler_reg     <= 1'b1;
            state_reg          <= HANDLER;
          end
        end
        HANDLER: begin
          // A fault inside the handler wins over a coincident ERET.
          if (bus.instr_valid) begin
            if (sync_exc) begin
              halted_reg <= 1'b1;
              state_reg  <= HALT;
            end else if (bus.eret) begin
              redirect_pc_reg    <= epc_reg;
              flush_reg          <= 1'b1;
              redirect_valid_reg <= 1'b1;
              state_reg          <= RET;
            end
          end
        end
        RET: begin
          flush_reg <= 1'b0;
          if (bus.redirect_ack) begin
            redirect_valid_reg <= 1'b0;
            ie_reg             <= 1'b1;
            in_handler_reg     <= 1'b0;
            state_reg          <= IDLE;
          end
        end
        HALT: begin
          halted_reg <= 1'b1;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

`ifdef EXC_COUNT_EN
  logic [15:0] count_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= 16'h0;
    end else if (state_reg == IDLE && event_hit && count_reg != 16'hFFFF) begin
      count_reg <= count_reg + 16'd1;
    end
  end

  assign bus.exc_count = count_reg;
`endif

  assign bus.flush          = flush_reg;
  assign bus.redirect_valid = redirect_valid_reg;
  assign bus.redirect_pc    = redirect_pc_reg;
  assign bus.cause          = cause_reg;
  assign bus.epc            = epc_reg;
  assign bus.ie             = ie_reg;
  assign bus.in_handler     = in_handler_reg;
  assign bus.halted         = halted_reg;

endmodule
